// File: rtl/shake_arbiter.sv
// Round-robin arbiter that lends the single SHAKE core to one requester per
// transaction (header, input words, output words) and routes its handshakes.
module shake_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 64,
  parameter int LEN_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid_in,
  input  logic [N_REQ*W-1:0] req_data_in,
  output logic [N_REQ-1:0]   req_ready_out,
  output logic [N_REQ-1:0]   req_valid_out,
  input  logic [N_REQ-1:0]   req_ready_in,
  output logic [W-1:0]       req_data_out,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               shake_valid_in,
  output logic [W-1:0]       shake_data_in,
  input  logic               shake_ready_out,
  input  logic               shake_valid_out,
  input  logic [W-1:0]       shake_data_out,
  output logic               shake_ready_in
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [2:0] {IDLE, HEADER, INPUT, OUTPUT, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

  logic [W-1:0]       g_data;
  logic [CNT_W-1:0]   hdr_in_words;
  logic [CNT_W-1:0]   hdr_out_words;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;

  // One extra bit keeps the rounding add from wrapping at the maximum length.
  function automatic logic [CNT_W-1:0] words(input logic [LEN_W-1:0] len);
    logic [CNT_W-1:0] wide;
    wide = {1'b0, len} + CNT_W'(W - 1);
    return wide / CNT_W'(W);
  endfunction

  assign g_data        = req_data_in[gidx_q*W +: W];
  assign hdr_in_words  = words(g_data[2*LEN_W-1:LEN_W]);
  assign hdr_out_words = words(g_data[LEN_W-1:0]);

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = int'(rr_ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!pick_valid && req_valid_in[PTR_W'(k)]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'(k);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    rr_ptr_d       = rr_ptr_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    req_ready_out  = '0;
    req_valid_out  = '0;
    shake_valid_in = 1'b0;
    shake_data_in  = '0;
    shake_ready_in = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = N_REQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = HEADER;
        end
      end
      HEADER, INPUT: begin
        shake_valid_in          = req_valid_in[gidx_q];
        shake_data_in           = g_data;
        req_ready_out[gidx_q]   = shake_ready_out;
        if (req_valid_in[gidx_q] && shake_ready_out) begin
          if (state_q == HEADER) begin
            in_cnt_d  = hdr_in_words;
            out_cnt_d = hdr_out_words;
            if (hdr_in_words != '0) begin
              state_d = INPUT;
            end else if (hdr_out_words != '0) begin
              state_d = OUTPUT;
            end else begin
              state_d = RELEASE;
              grant_d = '0;
            end
          end else begin
            in_cnt_d = in_cnt_q - 1'b1;
            if (in_cnt_q == CNT_W'(1)) begin
              if (out_cnt_q != '0) begin
                state_d = OUTPUT;
              end else begin
                state_d = RELEASE;
                grant_d = '0;
              end
            end
          end
        end
      end
      OUTPUT: begin
        shake_ready_in        = req_ready_in[gidx_q];
        req_valid_out[gidx_q] = shake_valid_out;
        if (shake_valid_out && req_ready_in[gidx_q]) begin
          out_cnt_d = out_cnt_q - 1'b1;
          if (out_cnt_q == CNT_W'(1)) begin
            state_d = RELEASE;
            grant_d = '0;
          end
        end
      end
      RELEASE: begin
        rr_ptr_d = (int'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = |grant_q;
  assign req_data_out = shake_data_out;

  // A grant exists exactly while a transaction is being routed.
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_busy_match:   assert property (@(posedge clk) disable iff (rst) busy == (|grant_q));
  a_grant_state:  assert property (@(posedge clk) disable iff (rst)
                    ((state_q == IDLE) || (state_q == RELEASE)) == (grant_q == '0));

endmodule

// File: tb/tb_shake_arbiter.sv
// Randomized bench for shake_arbiter: the bench plays both the requesters and
// the SHAKE core, predicting beat counts and grant order from header lengths.
module tb_shake_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int LW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid_in;
  logic [N*W-1:0] req_data_in;
  logic [N-1:0]   req_ready_out;
  logic [N-1:0]   req_valid_out;
  logic [N-1:0]   req_ready_in;
  logic [W-1:0]   req_data_out;
  logic [N-1:0]   grant;
  logic           busy;
  logic           shake_valid_in;
  logic [W-1:0]   shake_data_in;
  logic           shake_ready_out;
  logic           shake_valid_out;
  logic [W-1:0]   shake_data_out;
  logic           shake_ready_in;

  int errors = 0;
  int checks = 0;
  int rr_model = 0;

  shake_arbiter #(.N_REQ(N), .W(W), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out), .req_valid_out(req_valid_out),
    .req_ready_in(req_ready_in), .req_data_out(req_data_out),
    .grant(grant), .busy(busy),
    .shake_valid_in(shake_valid_in), .shake_data_in(shake_data_in),
    .shake_ready_out(shake_ready_out), .shake_valid_out(shake_valid_out),
    .shake_data_out(shake_data_out), .shake_ready_in(shake_ready_in)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk_hdr(input longint in_len, input longint out_len);
    return {in_len[31:0], out_len[31:0]};
  endfunction

  function automatic int ceil_words(input longint len);
    return int'((len + W - 1) / W);
  endfunction

  task automatic set_slice(input int r, input logic [W-1:0] v);
    req_data_in[r*W +: W] = v;
  endtask

  task automatic idle_inputs();
    req_valid_in    = '0;
    req_data_in     = '0;
    req_ready_in    = '0;
    shake_ready_out = 1'b0;
    shake_valid_out = 1'b0;
    shake_data_out  = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if (grant !== '0 || busy !== 1'b0 || req_ready_out !== '0 || req_valid_out !== '0 ||
        shake_valid_in !== 1'b0 || shake_ready_in !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: grant=%b busy=%b rdy_o=%b vld_o=%b svi=%b sri=%b, expected all 0",
               tag, grant, busy, req_ready_out, req_valid_out, shake_valid_in, shake_ready_in);
    end
  endtask

  // Runs one whole transaction for requester r and checks routing every cycle.
  task automatic do_txn(input int r, input longint in_len, input longint out_len,
                        input bit bp, input int exp_lat, input bit keep_req);
    int n_in, n_out, sent, recv, lat, cyc;
    logic [N-1:0] mask;
    logic [W-1:0] word;
    n_in  = ceil_words(in_len);
    n_out = ceil_words(out_len);
    mask  = N'(1) << r;
    word  = mk_hdr(in_len, out_len);
    set_slice(r, word);
    req_valid_in[r] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (grant === '0 && lat < 20);
    checks++;
    if (grant !== mask || lat != exp_lat) begin
      errors++;
      $display("[TB] FAIL grant_lat r=%0d: grant=%b lat=%0d, expected grant=%b lat=%0d",
               r, grant, lat, mask, exp_lat);
      return;
    end
    sent = 0; recv = 0; cyc = 0;
    while ((sent < 1 + n_in || recv < n_out) && cyc < 3000) begin
      cyc++;
      req_ready_in = N'($urandom);
      if (sent < 1 + n_in) begin
        req_valid_in[r] = bp ? 1'($urandom_range(0, 3) != 0) : 1'b1;
        shake_ready_out = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        set_slice(r, word);
        shake_valid_out = 1'($urandom_range(0, 1));
        shake_data_out  = {$urandom, $urandom};
      end else begin
        req_valid_in[r] = bp ? 1'($urandom_range(0, 1)) : 1'b0;
        shake_ready_out = 1'($urandom_range(0, 1));
        shake_valid_out = bp ? 1'($urandom_range(0, 2) != 0) : 1'b1;
        shake_data_out  = {$urandom, $urandom};
        req_ready_in[r] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      checks++;
      if (grant !== mask || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hold r=%0d cyc=%0d: grant=%b busy=%b, expected grant=%b busy=1",
                 r, cyc, grant, busy, mask);
      end
      checks++;
      if ((req_ready_out & ~mask) !== '0 || (req_valid_out & ~mask) !== '0 ||
          req_data_out !== shake_data_out) begin
        errors++;
        $display("[TB] FAIL leak r=%0d cyc=%0d: rdy_o=%b vld_o=%b dout=%h, expected others 0 dout=%h",
                 r, cyc, req_ready_out, req_valid_out, req_data_out, shake_data_out);
      end
      checks++;
      if (sent < 1 + n_in) begin
        if (shake_valid_in !== req_valid_in[r] || req_ready_out[r] !== shake_ready_out ||
            shake_ready_in !== 1'b0 || req_valid_out[r] !== 1'b0 ||
            (req_valid_in[r] && shake_data_in !== word)) begin
          errors++;
          $display("[TB] FAIL in_route r=%0d beat=%0d: svi=%b rdy=%b sri=%b din=%h, expected svi=%b rdy=%b sri=0 din=%h",
                   r, sent, shake_valid_in, req_ready_out[r], shake_ready_in, shake_data_in,
                   req_valid_in[r], shake_ready_out, word);
        end
        if (req_valid_in[r] && shake_ready_out) begin
          sent++;
          word = {$urandom, $urandom};
        end
      end else begin
        if (shake_valid_in !== 1'b0 || req_ready_out !== '0 ||
            shake_ready_in !== req_ready_in[r] || req_valid_out[r] !== shake_valid_out) begin
          errors++;
          $display("[TB] FAIL out_route r=%0d beat=%0d: svi=%b rdy_o=%b sri=%b vld=%b, expected svi=0 rdy_o=0 sri=%b vld=%b",
                   r, recv, shake_valid_in, req_ready_out, shake_ready_in, req_valid_out[r],
                   req_ready_in[r], shake_valid_out);
        end
        if (shake_valid_out && req_ready_in[r]) recv++;
      end
      @(negedge clk); #1;
    end
    if (sent < 1 + n_in || recv < n_out) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout r=%0d: sent=%0d recv=%0d, expected sent=%0d recv=%0d",
               r, sent, recv, 1 + n_in, n_out);
    end
    req_valid_in[r] = keep_req;
    if (keep_req) set_slice(r, mk_hdr(in_len, out_len));
    shake_valid_out = 1'b1;
    shake_ready_out = 1'b1;
    req_ready_in    = '1;
    #1;
    check_quiet("release");
    rr_model = (r + 1) % N;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req_valid_in    = '1;
    req_ready_in    = '1;
    shake_valid_out = 1'b1;
    shake_ready_out = 1'b1;
    #2;
    check_quiet("reset_async");
    @(negedge clk); #1;
    check_quiet("reset_edge");
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
  endtask

  task automatic test_single();
    wait_cycles(2);
    do_txn(1, 128, 256, 1'b0, 1, 1'b0);
    wait_cycles(1);
    checks++;
    if (dut.rr_ptr_q !== 2'(rr_model) || rr_model != 2) begin
      errors++;
      $display("[TB] FAIL rr_ptr_single: got %0d, expected 2", dut.rr_ptr_q);
    end
  endtask

  task automatic test_round_robin();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    @(negedge clk); rst = 1'b1;
    idle_inputs();
    @(negedge clk); rst = 1'b0;
    rr_model = 0;
    for (int r = 0; r < N; r++) set_slice(r, mk_hdr(64, 64));
    req_valid_in = '1;
    for (int k = 0; k < 5; k++) begin
      do_txn(order[k], 64, 64, 1'b0, (k == 0) ? 1 : 2, k < 4);
    end
    req_valid_in = '0;
    wait_cycles(3);
    check_quiet("rr_idle");
  endtask

  task automatic test_zero_len();
    int r;
    r = $urandom_range(0, N - 1);
    wait_cycles(2);
    do_txn(r, 0, 0, 1'b0, 1, 1'b0);
    wait_cycles(2);
    do_txn(r, 0, 64, 1'b0, 1, 1'b0);
  endtask

  task automatic test_backpressure();
    wait_cycles(2);
    do_txn($urandom_range(0, N - 1), 200, 1344, 1'b1, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_cycles(2);
      do_txn($urandom_range(0, N - 1), longint'($urandom_range(0, 300)),
             longint'($urandom_range(0, 300)), 1'b1, 1, 1'b0);
    end
  endtask

  task automatic test_rounding();
    wait_cycles(2);
    do_txn(1, 1, 65, 1'b0, 1, 1'b0);
  endtask

  // Huge input length, check the loaded count, then abort with reset mid-INPUT.
  task automatic test_reset_mid_input();
    longint big;
    int lat;
    logic [LW:0] exp_in;
    big    = 64'hFFFF_FFFF;
    exp_in = (LW + 1)'(ceil_words(big));
    wait_cycles(2);
    set_slice(2, mk_hdr(big, 64));
    req_valid_in[2] = 1'b1;
    shake_ready_out = 1'b1;
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (grant === '0 && lat < 20);
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL grant_r2: got %b, expected 0100", grant);
    end
    @(negedge clk); #1;
    checks++;
    if (dut.in_cnt_q !== exp_in || exp_in != 33'h400_0000 || dut.out_cnt_q !== 33'd1) begin
      errors++;
      $display("[TB] FAIL cnt_load: in=%0d out=%0d, expected in=%0d out=1",
               dut.in_cnt_q, dut.out_cnt_q, exp_in);
    end
    set_slice(2, {$urandom, $urandom});
    @(negedge clk); #1;
    checks++;
    if (dut.in_cnt_q !== exp_in - 1'b1 || grant !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL cnt_dec: in=%0d grant=%b, expected in=%0d grant=0100",
               dut.in_cnt_q, grant, exp_in - 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    check_quiet("rst_mid_async");
    @(posedge clk); #1;
    check_quiet("rst_mid_edge");
    checks++;
    if (dut.rr_ptr_q !== '0) begin
      errors++;
      $display("[TB] FAIL rr_ptr_reset: got %0d, expected 0", dut.rr_ptr_q);
    end
    for (int r = 0; r < N; r++) set_slice(r, mk_hdr(64, 64));
    req_valid_in = '1;
    @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
    do_txn(0, 64, 64, 1'b0, 1, 1'b0);
    req_valid_in = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_backpressure();
    test_rounding();
    test_reset_mid_input();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
